// File: rtl/vga_fb_prefetch_if.sv
// Handshake and BRAM bus bundle for the framebuffer prefetch engine.
// The engine connects through the slave modport; the requester/BRAM/VGA side uses master.
interface vga_fb_prefetch_if #(
    parameter int AW = 17
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] bram_addra;
    logic [AW-1:0] bram_addrb;
    logic [7:0]    bram_douta;
    logic [7:0]    bram_doutb;
    logic          out_valid;
    logic          out_ready;
    logic [47:0]   out_data;
    logic          busy;

    modport master (
        output req_valid, req_addr, bram_douta, bram_doutb, out_ready,
        input  req_ready, bram_addra, bram_addrb, out_valid, out_data, busy
    );

    modport slave (
        input  req_valid, req_addr, bram_douta, bram_doutb, out_ready,
        output req_ready, bram_addra, bram_addrb, out_valid, out_data, busy
    );
endinterface

// File: rtl/vga_fb_prefetch.sv
// Framebuffer fetch engine: three two-byte BRAM beats per 48-bit word,
// little-endian assembly, and a small output FIFO drained by the VGA side.
//
//   state | meaning
//   IDLE  | waiting for a request; accepts when enough FIFO slots are free
//   ISSUE | driving BRAM addresses, one beat per cycle, 3*WORDS beats
module vga_fb_prefetch #(
    parameter int WORDS      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 17
) (
    input  logic                 clk_75mhz_internal,
    input  logic                 rst,
    vga_fb_prefetch_if.slave     bus
);
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    beat_q, beat_d;
    logic [WW-1:0] word_q, word_d;
    logic          cap_valid_q, cap_valid_d;
    logic [1:0]    cap_beat_q, cap_beat_d;
    logic [31:0]   asm_q, asm_d;
    logic [47:0]   mem_q [FIFO_DEPTH];
    logic [47:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] resv_q, resv_d;

    logic ready_int;
    logic accept;
    logic issue;
    logic last_beat;
    logic push;
    logic pop;

    // resv_q counts stored words plus words still being fetched, so a push can never overflow
    assign ready_int = (state_q == IDLE) && ((DEPTH_C - resv_q) >= WORDS_C);
    assign accept    = bus.req_valid && ready_int;
    assign issue     = (state_q == ISSUE);
    assign last_beat = issue && (beat_q == 2'd2) && (word_q == WW'(WORDS - 1));
    assign push      = cap_valid_q && (cap_beat_q == 2'd2);
    assign pop       = (count_q != '0) && bus.out_ready;

    always_ff @(posedge clk_75mhz_internal) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            word_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_beat_q  <= '0;
            asm_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resv_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            word_q      <= word_d;
            cap_valid_q <= cap_valid_d;
            cap_beat_q  <= cap_beat_d;
            asm_q       <= asm_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            resv_q      <= resv_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        beat_d      = beat_q;
        word_d      = word_q;
        asm_d       = asm_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        resv_d      = resv_q;
        cap_valid_d = issue;
        cap_beat_d  = beat_q;

        // Running address replaces base + 2*(3*word+beat); AW-bit adds give the wrap for free
        if (accept) begin
            addr_d = {bus.req_addr[AW-1:1], 1'b0};
            beat_d = '0;
            word_d = '0;
        end else if (issue) begin
            addr_d = addr_q + AW'(2);
            if (beat_q == 2'd2) begin
                beat_d = '0;
                word_d = word_q + WW'(1);
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end

        if (cap_valid_q && (cap_beat_q == 2'd0)) asm_d[15:0]  = {bus.bram_doutb, bus.bram_douta};
        if (cap_valid_q && (cap_beat_q == 2'd1)) asm_d[31:16] = {bus.bram_doutb, bus.bram_douta};

        if (push) begin
            mem_d[wr_ptr_q] = {bus.bram_doutb, bus.bram_douta, asm_q};
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        if (push && !pop) count_d = count_q + CW'(1);
        if (!push && pop) count_d = count_q - CW'(1);

        if (accept) resv_d = resv_d + WORDS_C;
        if (pop)    resv_d = resv_d - CW'(1);
    end

    always_comb begin
        bus.req_ready  = ready_int;
        bus.bram_addra = addr_q;
        bus.bram_addrb = addr_q + AW'(1);
        bus.out_valid  = (count_q != '0);
        bus.out_data   = mem_q[rd_ptr_q];
        bus.busy       = (state_q != IDLE) || cap_valid_q;
    end
endmodule

// File: tb/tb_vga_fb_prefetch.sv
// Bench for vga_fb_prefetch: one WORDS=1 and one WORDS=2 instance, checked
// against a transaction-level model (expected-word queues and cycle budgets).
module tb_vga_fb_prefetch;
    localparam int AW    = 17;
    localparam int DEPTH = 4;

    logic clk_75mhz_internal = 1'b0;
    always #5 clk_75mhz_internal = ~clk_75mhz_internal;

    logic rst1, rst2;
    logic [7:0] key;

    vga_fb_prefetch_if #(.AW(AW)) if1 ();
    vga_fb_prefetch_if #(.AW(AW)) if2 ();

    vga_fb_prefetch #(.WORDS(1), .FIFO_DEPTH(DEPTH), .AW(AW)) dut1 (
        .clk_75mhz_internal(clk_75mhz_internal), .rst(rst1), .bus(if1));
    vga_fb_prefetch #(.WORDS(2), .FIFO_DEPTH(DEPTH), .AW(AW)) dut2 (
        .clk_75mhz_internal(clk_75mhz_internal), .rst(rst2), .bus(if2));

    // key == 0 gives mem[i] = i[7:0]; otherwise a scrambled but address-dependent pattern
    function automatic logic [7:0] pat(logic [AW-1:0] a);
        if (key == 8'd0) return a[7:0];
        return a[7:0] ^ a[16:9] ^ key;
    endfunction

    always @(posedge clk_75mhz_internal) begin
        if1.bram_douta <= pat(if1.bram_addra);
        if1.bram_doutb <= pat(if1.bram_addrb);
        if2.bram_douta <= pat(if2.bram_addra);
        if2.bram_doutb <= pat(if2.bram_addrb);
    end

    function automatic logic [47:0] exp_word(logic [AW-1:0] addr, int idx);
        logic [47:0]   w;
        logic [AW-1:0] a;
        a = {addr[AW-1:1], 1'b0} + AW'(6 * idx);
        for (int j = 0; j < 6; j++) w[8*j +: 8] = pat(a + AW'(j));
        return w;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // model state: words accepted but not yet popped, and cycle budgets for issue/busy
    logic [47:0] q1[$];
    logic [47:0] q2[$];
    int rem  [2];
    int brem [2];
    bit acc  [2];

    task automatic sb(int k, bit r, bit rv, bit rr, logic [AW-1:0] ra,
                      bit ov, bit ordy, logic [47:0] od, bit bz, int w);
        int sz;
        logic [47:0] head;
        sz = (k == 0) ? q1.size() : q2.size();
        check($sformatf("req_ready%0d", k), 48'(rr), 48'((rem[k] == 0) && ((DEPTH - sz) >= w)));
        check($sformatf("busy%0d", k), 48'(bz), 48'(brem[k] > 0));
        if (sz == 0) check($sformatf("out_valid_empty%0d", k), 48'(ov), 48'd0);
        acc[k] = 1'b0;
        if (r) begin
            if (k == 0) q1.delete(); else q2.delete();
            rem[k]  = 0;
            brem[k] = 0;
        end else begin
            if (ov && ordy && sz > 0) begin
                head = (k == 0) ? q1.pop_front() : q2.pop_front();
                check($sformatf("out_data%0d", k), od, head);
            end
            if (rv && rr) begin
                for (int i = 0; i < w; i++) begin
                    if (k == 0) q1.push_back(exp_word(ra, i));
                    else        q2.push_back(exp_word(ra, i));
                end
                rem[k]  = 3 * w;
                brem[k] = 3 * w + 1;
                acc[k]  = 1'b1;
            end else begin
                if (rem[k] > 0)  rem[k]--;
                if (brem[k] > 0) brem[k]--;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_75mhz_internal);
        sb(0, rst1, if1.req_valid, if1.req_ready, if1.req_addr, if1.out_valid,
           if1.out_ready, if1.out_data, if1.busy, 1);
        sb(1, rst2, if2.req_valid, if2.req_ready, if2.req_addr, if2.out_valid,
           if2.out_ready, if2.out_data, if2.busy, 2);
        @(posedge clk_75mhz_internal);
        #1;
    endtask

    task automatic drain(int budget);
        if1.req_valid = 1'b0;
        if2.req_valid = 1'b0;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (q1.size() == 0 && q2.size() == 0 && rem[0] == 0 && rem[1] == 0) break;
            cyc();
        end
        cyc();
        check("drain_q1", 48'(q1.size()), 48'd0);
        check("drain_q2", 48'(q2.size()), 48'd0);
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
    endtask

    logic [AW-1:0] addr_b;
    int n_acc;

    initial begin
        key = 8'd0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        if1.req_valid = 1'b0; if1.req_addr = '0; if1.out_ready = 1'b0;
        if2.req_valid = 1'b0; if2.req_addr = '0; if2.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin rem[i] = 0; brem[i] = 0; acc[i] = 1'b0; end
        repeat (2) @(posedge clk_75mhz_internal);
        #1;
        check("rst_out_valid", 48'(if1.out_valid), 48'd0);
        check("rst_out_data", if1.out_data, 48'd0);
        check("rst_busy", 48'(if1.busy), 48'd0);
        check("rst_addra", 48'(if1.bram_addra), 48'd0);
        check("rst_addrb", 48'(if1.bram_addrb), 48'd1);
        check("rst_req_ready", 48'(if1.req_ready), 48'd1);
        check("rst_out_valid2", 48'(if2.out_valid), 48'd0);
        rst1 = 1'b0;
        rst2 = 1'b0;

        // single word from 0x00100, out_valid exactly four edges after accept
        if1.req_addr = 17'h00100;
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        check("first_addra", 48'(if1.bram_addra), 48'h00100);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check($sformatf("latency_valid_e%0d", i), 48'(if1.out_valid), 48'(i == 4));
        end
        check("word_0x100", if1.out_data, 48'h050403020100);
        drain(20);

        // address wrap at the top of the BRAM
        if1.req_addr = 17'h1FFFE;
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        check("wrap_addra0", 48'(if1.bram_addra), 48'h1FFFE);
        check("wrap_addrb0", 48'(if1.bram_addrb), 48'h1FFFF);
        cyc();
        check("wrap_addra1", 48'(if1.bram_addra), 48'h00000);
        check("wrap_addrb1", 48'(if1.bram_addrb), 48'h00001);
        cyc();
        check("wrap_addra2", 48'(if1.bram_addra), 48'h00002);
        check("wrap_addrb2", 48'(if1.bram_addrb), 48'h00003);
        repeat (3) cyc();
        check("wrap_word", if1.out_data, 48'h03020100FFFE);
        drain(20);

        // odd address behaves as the even one below it
        if1.req_addr = 17'h00101;
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        repeat (4) cyc();
        check("odd_addr_word", if1.out_data, 48'h050403020100);
        drain(20);

        // reset while beat1 is being issued: nothing must come out
        if1.req_addr = AW'($urandom);
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        cyc();
        rst1 = 1'b1;
        cyc();
        rst1 = 1'b0;
        check("midrst_out_valid", 48'(if1.out_valid), 48'd0);
        check("midrst_busy", 48'(if1.busy), 48'd0);
        check("midrst_req_ready", 48'(if1.req_ready), 48'd1);
        if1.out_ready = 1'b1;
        repeat (6) cyc();
        check("midrst_no_word", 48'(if1.out_valid), 48'd0);
        if1.out_ready = 1'b0;

        // push and pop on the same edge with one entry resident
        if1.req_addr = AW'($urandom);
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        repeat (4) cyc();
        addr_b = AW'($urandom);
        if1.req_addr = addr_b;
        if1.req_valid = 1'b1;
        cyc();
        if1.req_valid = 1'b0;
        repeat (3) cyc();
        if1.out_ready = 1'b1;
        cyc();
        if1.out_ready = 1'b0;
        check("pushpop_valid", 48'(if1.out_valid), 48'd1);
        check("pushpop_data", if1.out_data, exp_word(addr_b, 0));
        cyc();
        check("hold_data", if1.out_data, exp_word(addr_b, 0));
        if1.out_ready = 1'b1;
        cyc();
        if1.out_ready = 1'b0;
        check("pushpop_occ1", 48'(if1.out_valid), 48'd0);

        // WORDS=2: slot reservation blocks the third request
        if2.req_addr = AW'($urandom);
        if2.req_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (acc[1]) begin
                n_acc++;
                if2.req_addr = AW'($urandom);
            end
        end
        check("w2_accepts", 48'(n_acc), 48'd2);
        check("w2_third_blocked", 48'(if2.req_ready), 48'd0);
        if2.req_valid = 1'b0;
        if2.out_ready = 1'b1;
        cyc();
        if2.out_ready = 1'b0;
        check("w2_one_pop", 48'(if2.req_ready), 48'd0);
        if2.out_ready = 1'b1;
        cyc();
        if2.out_ready = 1'b0;
        check("w2_two_pops", 48'(if2.req_ready), 48'd1);
        drain(40);

        // randomized traffic on both instances against the model
        key = 8'($urandom_range(1, 255));
        for (int c = 0; c < 600; c++) begin
            if1.out_ready = 1'($urandom);
            if2.out_ready = 1'($urandom_range(0, 3) == 0);
            cyc();
            if (acc[0] || !if1.req_valid) begin
                if1.req_valid = 1'($urandom);
                if1.req_addr  = AW'($urandom);
            end
            if (acc[1] || !if2.req_valid) begin
                if2.req_valid = 1'($urandom);
                if2.req_addr  = AW'($urandom);
            end
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
